// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types and constants for the pattern serializer path
package pattern_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;
  localparam logic SERIAL_IDLE_LEVEL = 1'b0;
endpackage

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - clearable, enable-gated bit counter with terminal-count flag
module ser_bit_counter #(
  parameter int DATA_WIDTH = 8,
  localparam int CW = $clog2(DATA_WIDTH)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [CW-1:0] r_count;

  // Clear wins over enable so a word load on the last bit restarts at zero
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == CW'(DATA_WIDTH - 1));
endmodule

// File: rtl/pattern_bit_serializer.sv
// rtl/pattern_bit_serializer.sv - parallel-to-serial front end with one-word holding buffer
module pattern_bit_serializer
  import pattern_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  shift_strobe,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  word_done,
  output logic                  busy
);
  ser_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;

  logic                  w_shifting;
  logic                  w_accept;
  logic                  w_tc;
  logic                  w_last;
  logic                  w_load;
  logic                  w_head;
  logic [DATA_WIDTH-1:0] w_advanced;

  assign w_shifting = (r_state == SHIFT);
  assign w_accept   = data_valid && !r_hold_full;
  assign w_last     = w_shifting && shift_strobe && w_tc;
  assign w_load     = ((r_state == IDLE) && w_accept) || w_last;
  assign w_head     = MSB_FIRST ? r_shift[DATA_WIDTH-1] : r_shift[0];
  assign w_advanced = MSB_FIRST ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, r_shift[DATA_WIDTH-1:1]};

  ser_bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_bit_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .i_clr (w_load),
    .i_en  (w_shifting && shift_strobe),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= data_in;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last) begin
            // Held word takes priority; data_ready is low while it is full
            if (r_hold_full) begin
              r_shift     <= r_hold;
              r_hold_full <= 1'b0;
            end else if (w_accept) begin
              r_shift <= data_in;
            end else begin
              r_shift <= '0;
              r_state <= IDLE;
            end
          end else begin
            if (shift_strobe) r_shift <= w_advanced;
            if (w_accept) begin
              r_hold      <= data_in;
              r_hold_full <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_ready   = !r_hold_full;
  assign serial_out   = w_shifting ? w_head : SERIAL_IDLE_LEVEL;
  assign serial_valid = w_shifting;
  assign word_done    = w_last;
  assign busy         = w_shifting || r_hold_full;
endmodule

// File: tb/tb_pattern_bit_serializer.sv
// tb/tb_pattern_bit_serializer.sv - self-checking bench for pattern_bit_serializer
module tb_pattern_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         shift_strobe = 1'b0;
  logic         rdy0, so0, sv0, wd0, bz0;
  logic         rdy1, so1, sv1, wd1, bz1;

  always #5 clk = ~clk;

  pattern_bit_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy0), .shift_strobe(shift_strobe), .serial_out(so0),
    .serial_valid(sv0), .word_done(wd0), .busy(bz0));

  pattern_bit_serializer #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .n_rst(n_rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy1), .shift_strobe(shift_strobe), .serial_out(so1),
    .serial_valid(sv1), .word_done(wd1), .busy(bz1));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: active word with count of bits still to send, plus one held word
  logic [W-1:0] m_w, m_h;
  int           m_n;
  bit           m_hf;

  logic [31:0] stream0, stream1;
  int          done_cnt, sv_cnt, rdy_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_w = '0; m_h = '0; m_n = 0; m_hf = 1'b0;
  endtask

  function automatic logic [4:0] m_exp(input bit msb);
    int   k;
    logic sv, so;
    k  = W - m_n;
    sv = (m_n > 0);
    so = sv ? (msb ? m_w[W-1-k] : m_w[k]) : 1'b0;
    return {so, sv, sv && shift_strobe && (m_n == 1), !m_hf, sv || m_hf};
  endfunction

  task automatic m_step(input logic v, input logic [W-1:0] d, input logic s);
    bit acc;
    acc = v && !m_hf;
    if (m_n == 1 && s) begin
      if (m_hf) begin m_w = m_h; m_n = W; m_hf = 1'b0; end
      else if (acc) begin m_w = d; m_n = W; end
      else m_n = 0;
    end else begin
      if (m_n > 0 && s) m_n--;
      if (acc) begin
        if (m_n > 0) begin m_h = d; m_hf = 1'b1; end
        else begin m_w = d; m_n = W; end
      end
    end
  endtask

  task automatic clear_stats();
    stream0 = '0; stream1 = '0; done_cnt = 0; sv_cnt = 0; rdy_low = 0;
  endtask

  // One clock: drive, sample at negedge against the model, then advance the model
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic s);
    data_valid = v; data_in = d; shift_strobe = s;
    @(negedge clk);
    check("cycle_msb", {27'd0, so0, sv0, wd0, rdy0, bz0}, {27'd0, m_exp(1'b1)});
    check("cycle_lsb", {27'd0, so1, sv1, wd1, rdy1, bz1}, {27'd0, m_exp(1'b0)});
    if (sv0 && s) stream0 = {stream0[30:0], so0};
    if (sv1 && s) stream1 = {stream1[30:0], so1};
    if (wd0) done_cnt++;
    if (sv0) sv_cnt++;
    if (!rdy0) rdy_low++;
    @(posedge clk);
    m_step(v, d, s);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_msb"}, {27'd0, so0, sv0, wd0, rdy0, bz0}, 32'b00010);
    check({name, "_lsb"}, {27'd0, so1, sv1, wd1, rdy1, bz1}, 32'b00010);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         s;
    logic [4:0]   exp;  // {serial_out, serial_valid, word_done, data_ready, busy}
  } vec_t;

  vec_t         tbl[10];
  logic [W-1:0] pat;

  initial begin
    m_reset();
    clear_stats();
    #2;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Single word 8'hD0, MSB first, strobe tied high
    pat = 8'hD0;
    tbl[0] = '{1'b1, 8'hD0, 1'b1, 5'b00010};
    for (int c = 1; c <= 8; c++)
      tbl[c] = '{1'b0, 8'h00, 1'b1, {pat[8-c], 1'b1, (c == 8), 1'b1, 1'b1}};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 5'b00010};
    for (int i = 0; i < 10; i++) begin
      data_valid = tbl[i].v; data_in = tbl[i].d; shift_strobe = tbl[i].s;
      @(negedge clk);
      check($sformatf("table_c%0d", i), {27'd0, so0, sv0, wd0, rdy0, bz0}, {27'd0, tbl[i].exp});
      check($sformatf("table_lsb_c%0d", i), {27'd0, so1, sv1, wd1, rdy1, bz1}, {27'd0, m_exp(1'b0)});
      @(posedge clk);
      m_step(tbl[i].v, tbl[i].d, tbl[i].s);
      #1;
    end

    // Back-to-back through the holding buffer
    clear_stats();
    cycle(1'b1, 8'hD0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hB4, 1'b1);
    for (int c = 3; c <= 17; c++) cycle(1'b0, 8'h00, 1'b1);
    check("b2b_stream", stream0[15:0], 16'hD0B4);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_valid_cycles", sv_cnt, 16);
    check("b2b_ready_low", rdy_low, 6);

    // Accept coincident with last bit, hold empty
    clear_stats();
    cycle(1'b1, 8'hD0, 1'b1);
    for (int c = 1; c <= 7; c++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h5A, 1'b1);
    for (int c = 9; c <= 17; c++) cycle(1'b0, 8'h00, 1'b1);
    check("coinc_stream", stream0[15:0], 16'hD05A);
    check("coinc_valid_cycles", sv_cnt, 16);
    check("coinc_done_cnt", done_cnt, 2);

    // Strobe gating on cycles 3-5
    clear_stats();
    cycle(1'b1, 8'hD0, 1'b1);
    for (int c = 1; c <= 12; c++) cycle(1'b0, 8'h00, !(c >= 3 && c <= 5));
    check("gate_stream", stream0[7:0], 8'hD0);
    check("gate_done_cnt", done_cnt, 1);
    check("gate_valid_cycles", sv_cnt, 11);

    // LSB-first ordering of 8'h0B
    clear_stats();
    cycle(1'b1, 8'h0B, 1'b1);
    for (int c = 1; c <= 9; c++) cycle(1'b0, 8'h00, 1'b1);
    check("lsb_stream", stream1[7:0], 8'b11010000);

    // Asynchronous reset during bit 4 with a word held
    clear_stats();
    cycle(1'b1, 8'hD0, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hA5, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    data_valid = 1'b0; shift_strobe = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    check_reset_outputs("reset_midword");
    m_reset();
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    for (int c = 0; c < 12; c++) cycle(1'b0, 8'h00, 1'b1);
    check("reset_words_lost", sv_cnt, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
    for (int c = 0; c < 20; c++) cycle(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
